pc_unit: RTL

- Parametrised program-counter unit for the RV32I core; next generation of the plain PC register.
- Adds stall, branch/jump redirect, trap entry/return, misaligned-target detection, boot/bubble sequencing, and an optional PC history buffer.
- Sits at the head of fetch: drives the instruction-memory address and the PC consumed by decode/execute.

---
 rtl/pc_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for RV32I fetch: stall, redirect, trap entry/return, boot/bubble sequencing.
// Optional PC history buffer enabled by defining PC_HISTORY_EN.
module pc_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int                HIST_DEPTH   = 4
) (
  input  logic                          sinal_clk,
  input  logic                          sinal_rst,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_target,
  input  logic                          trap_req,
  input  logic                          trap_ret,
  input  logic [XLEN-1:0]               epc_in,
  output logic [XLEN-1:0]               saida_pc,
  output logic [XLEN-1:0]               pc_plus4,
  output logic                          pc_valid,
  output logic                          misaligned,
  output logic [XLEN-1:0]               epc_out,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [XLEN-1:0]               hist_pc
);

  localparam int              PW   = $clog2(HIST_DEPTH);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

  state_t state;
  logic   hist_wr;

  assign pc_plus4 = saida_pc + FOUR;

  // Every RUN edge that moves the PC (anything except a plain stall) is a history write.
  assign hist_wr = (state == RUN) && (trap_req || trap_ret || redirect_valid || !stall);

  always_ff @(posedge sinal_clk or posedge sinal_rst) begin
    if (sinal_rst) begin
      state      <= BOOT;
      saida_pc   <= RESET_VECTOR;
      pc_valid   <= 1'b0;
      misaligned <= 1'b0;
      epc_out    <= '0;
    end else begin
      misaligned <= 1'b0;
      if (trap_req) begin
        saida_pc <= TRAP_VECTOR;
        epc_out  <= epc_in;
        state    <= BUBBLE;
        pc_valid <= 1'b0;
      end else if (state != RUN) begin
        state    <= RUN;
        pc_valid <= 1'b1;
      end else if (trap_ret) begin
        saida_pc <= epc_out;
      end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
        // Misaligned target traps; the branch itself becomes the exception PC.
        saida_pc   <= TRAP_VECTOR;
        epc_out    <= saida_pc;
        misaligned <= 1'b1;
        state      <= BUBBLE;
        pc_valid   <= 1'b0;
      end else if (redirect_valid) begin
        saida_pc <= redirect_target;
      end else if (!stall) begin
        saida_pc <= pc_plus4;
      end
    end
  end

`ifdef PC_HISTORY_EN
  logic [XLEN-1:0] hist_mem [HIST_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointer arithmetic wraps naturally since HIST_DEPTH is a power of two.
  assign rd_ptr  = wr_ptr - PW'(1) - hist_idx;
  assign hist_pc = hist_mem[rd_ptr];

  always_ff @(posedge sinal_clk or posedge sinal_rst) begin
    if (sinal_rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else if (hist_wr) begin
      hist_mem[wr_ptr] <= saida_pc;
      wr_ptr           <= wr_ptr + PW'(1);
    end
  end
`else
  logic unused_hist;
  assign unused_hist = ^{hist_idx, hist_wr};
  assign hist_pc     = '0;
`endif

endmodule
